// File: rtl/uart_hex_display.sv
// ASCII hex entry for a UART receiver: hex digits collect in a 4-digit pending buffer and CR/LF commits them.
// The committed 16-bit value is scanned onto a common-anode, time-multiplexed 4-digit seven-segment display.
module uart_hex_display #(
  parameter int REFRESH_COUNT = 100_000,
  parameter int NBITS_REFRESH = 17,
  parameter int BLANK_LEADING = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  dataRX,
  input  logic        done,
  output logic [15:0] value,
  output logic        valid,
  output logic        error,
  output logic [2:0]  pendCount,
  output logic [3:0]  anodes,
  output logic [6:0]  segments
);

  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_ESC = 8'h1B;
  localparam logic [NBITS_REFRESH-1:0] LAST_COUNT = NBITS_REFRESH'(REFRESH_COUNT - 1);

  typedef enum logic [2:0] {
    CLS_HEX,
    CLS_EOL,
    CLS_BS,
    CLS_ESC,
    CLS_BAD
  } byteClass_t;

  logic [7:0]               r_capData;
  logic                     r_capValid;
  logic [15:0]              r_pend;
  logic [2:0]               r_pendCount;
  logic [15:0]              r_value;
  logic                     r_valid;
  logic                     r_error;
  logic [NBITS_REFRESH-1:0] r_refreshCnt;
  logic [1:0]               r_digitIdx;

  byteClass_t               w_class;
  logic [3:0]               w_nibble;
  logic [3:0]               w_shownNibble;
  logic                     w_blank;

  function automatic logic [6:0] hexGlyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_capValid <= 1'b0;
      r_capData  <= 8'h00;
    end else begin
      r_capValid <= done;
      if (done) r_capData <= dataRX;
    end
  end

  // Letters map to 10..15 via their low nibble plus 9 ('A'/'a' end in 1).
  always_comb begin
    w_class  = CLS_BAD;
    w_nibble = 4'h0;
    if (r_capData >= 8'h30 && r_capData <= 8'h39) begin
      w_class  = CLS_HEX;
      w_nibble = r_capData[3:0];
    end else if ((r_capData >= 8'h41 && r_capData <= 8'h46) ||
                 (r_capData >= 8'h61 && r_capData <= 8'h66)) begin
      w_class  = CLS_HEX;
      w_nibble = r_capData[3:0] + 4'd9;
    end else if (r_capData == ASCII_CR || r_capData == ASCII_LF) begin
      w_class = CLS_EOL;
    end else if (r_capData == ASCII_BS) begin
      w_class = CLS_BS;
    end else if (r_capData == ASCII_ESC) begin
      w_class = CLS_ESC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= 16'h0000;
      r_pendCount <= 3'd0;
      r_value     <= 16'h0000;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      if (r_capValid) begin
        case (w_class)
          CLS_HEX: begin
            r_pend <= {r_pend[11:0], w_nibble};
            if (r_pendCount != 3'd4) r_pendCount <= r_pendCount + 3'd1;
          end
          CLS_EOL: begin
            // An empty buffer ignores the line ending, so CR LF commits only once.
            if (r_pendCount != 3'd0) begin
              r_value     <= r_pend;
              r_valid     <= 1'b1;
              r_pend      <= 16'h0000;
              r_pendCount <= 3'd0;
            end
          end
          CLS_BS: begin
            r_pend <= r_pend >> 4;
            if (r_pendCount != 3'd0) r_pendCount <= r_pendCount - 3'd1;
          end
          CLS_ESC: begin
            r_pend      <= 16'h0000;
            r_pendCount <= 3'd0;
          end
          default: r_error <= 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_refreshCnt <= '0;
      r_digitIdx   <= 2'd0;
    end else if (r_refreshCnt == LAST_COUNT) begin
      r_refreshCnt <= '0;
      r_digitIdx   <= r_digitIdx + 2'd1;
    end else begin
      r_refreshCnt <= r_refreshCnt + 1'b1;
    end
  end

  // A digit blanks only when it and all higher digits are zero; digit 0 never blanks.
  always_comb begin
    w_shownNibble = 4'h0;
    w_blank       = 1'b0;
    case (r_digitIdx)
      2'd0: w_shownNibble = r_value[3:0];
      2'd1: begin
        w_shownNibble = r_value[7:4];
        w_blank       = (BLANK_LEADING != 0) && (r_value[15:4] == 12'h000);
      end
      2'd2: begin
        w_shownNibble = r_value[11:8];
        w_blank       = (BLANK_LEADING != 0) && (r_value[15:8] == 8'h00);
      end
      default: begin
        w_shownNibble = r_value[15:12];
        w_blank       = (BLANK_LEADING != 0) && (r_value[15:12] == 4'h0);
      end
    endcase
  end

  assign anodes    = ~(4'b0001 << r_digitIdx);
  assign segments  = w_blank ? 7'b1111111 : hexGlyph(w_shownNibble);
  assign value     = r_value;
  assign valid     = r_valid;
  assign error     = r_error;
  assign pendCount = r_pendCount;

endmodule

// File: tb/tb_uart_hex_display.sv
// Self-checking bench for uart_hex_display: byte streams are scored against a queue-based model of the
// hex entry rules, and the display scan is checked on a plain and a leading-zero-blanking instance.
module tb_uart_hex_display;

  localparam int REFRESH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  dataRX;
  logic        done;
  logic [15:0] value,     valueB;
  logic        valid,     validB;
  logic        error,     errorB;
  logic [2:0]  pendCount, pendCountB;
  logic [3:0]  anodes,    anodesB;
  logic [6:0]  segments,  segmentsB;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  uart_hex_display #(.REFRESH_COUNT(REFRESH), .NBITS_REFRESH(3), .BLANK_LEADING(0)) u_dut (
    .clk(clk), .rst(rst), .dataRX(dataRX), .done(done),
    .value(value), .valid(valid), .error(error), .pendCount(pendCount),
    .anodes(anodes), .segments(segments)
  );

  uart_hex_display #(.REFRESH_COUNT(REFRESH), .NBITS_REFRESH(3), .BLANK_LEADING(1)) u_dutBlank (
    .clk(clk), .rst(rst), .dataRX(dataRX), .done(done),
    .value(valueB), .valid(validB), .error(errorB), .pendCount(pendCountB),
    .anodes(anodesB), .segments(segmentsB)
  );

  logic [6:0] glyphs [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: pending digits as a queue, oldest first.
  logic [3:0]  modelDigits[$];
  logic [15:0] modelValue = 16'h0000;

  logic [7:0]  txBytes[$];
  logic [15:0] obsValue[$];
  logic        obsValid[$];
  logic        obsError[$];
  logic [2:0]  obsPend[$];
  logic [15:0] expValue[$];
  logic        expValid[$];
  logic        expError[$];
  logic [2:0]  expPend[$];
  logic [15:0] preValue;
  logic [2:0]  prePend;

  task automatic modelStep(input logic [7:0] b);
    logic        v = 1'b0;
    logic        e = 1'b0;
    logic        isHex = 1'b1;
    logic [3:0]  nib = 4'h0;
    logic [15:0] acc = 16'h0000;
    if (b >= "0" && b <= "9")      nib = 4'(b - 8'h30);
    else if (b >= "A" && b <= "F") nib = 4'(b - 8'h41 + 8'd10);
    else if (b >= "a" && b <= "f") nib = 4'(b - 8'h61 + 8'd10);
    else                           isHex = 1'b0;
    if (isHex) begin
      modelDigits.push_back(nib);
      if (modelDigits.size() > 4) void'(modelDigits.pop_front());
    end else if (b == 8'h0D || b == 8'h0A) begin
      if (modelDigits.size() > 0) begin
        foreach (modelDigits[i]) acc = acc * 16 + 16'(modelDigits[i]);
        modelValue = acc;
        modelDigits.delete();
        v = 1'b1;
      end
    end else if (b == 8'h08) begin
      if (modelDigits.size() > 0) void'(modelDigits.pop_back());
    end else if (b == 8'h1B) begin
      modelDigits.delete();
    end else begin
      e = 1'b1;
    end
    expValue.push_back(modelValue);
    expPend.push_back(3'(modelDigits.size()));
    expValid.push_back(v);
    expError.push_back(e);
  endtask

  function automatic logic [6:0] expSeg(input logic [15:0] v, input int idx, input bit blank);
    logic [15:0] upper = v >> (4 * idx);
    if (blank && idx != 0 && upper == 16'h0000) return 7'b1111111;
    return glyphs[upper[3:0]];
  endfunction

  function automatic int anodeIdx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Drives txBytes on consecutive cycles; sample k+2 reflects byte k.
  task automatic applyStimulus();
    int n = txBytes.size();
    preValue = modelValue;
    prePend  = 3'(modelDigits.size());
    obsValue.delete(); obsValid.delete(); obsError.delete(); obsPend.delete();
    expValue.delete(); expValid.delete(); expError.delete(); expPend.delete();
    foreach (txBytes[i]) modelStep(txBytes[i]);
    for (int k = 0; k < n + 3; k++) begin
      @(negedge clk);
      obsValue.push_back(value);
      obsValid.push_back(valid);
      obsError.push_back(error);
      obsPend.push_back(pendCount);
      if (k < n) begin
        done = 1'b1; dataRX = txBytes[k];
      end else begin
        done = 1'b0; dataRX = 8'h00;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; done = 1'b0; dataRX = 8'h00;
    @(negedge clk);
    @(negedge clk);
    assertCount++;
    if (value !== 16'h0000 || pendCount !== 3'd0 || valid !== 1'b0 || error !== 1'b0 ||
        anodes !== 4'b1110 || segments !== 7'b1000000) begin
      failCount++;
      $display("[TB] FAIL reset_state: value=%h pend=%0d valid=%b error=%b anodes=%b seg=%b, expected 0000/0/0/0/1110/1000000",
               value, pendCount, valid, error, anodes, segments);
    end
    rst = 1'b0;
    modelDigits.delete();
    modelValue = 16'h0000;
    for (int s = 0; s < 4 * REFRESH; s++) begin
      int idx = (s / REFRESH) % 4;
      logic [3:0] expAn = ~(4'b0001 << idx);
      assertCount++;
      if (anodes !== expAn || segments !== 7'b1000000 || value !== 16'h0000 ||
          anodesB !== expAn || segmentsB !== expSeg(16'h0000, idx, 1'b1)) begin
        failCount++;
        $display("[TB] FAIL idle_scan cycle%0d: anodes=%b seg=%b blankSeg=%b value=%h, expected anodes=%b seg=1000000 blankSeg=%b",
                 s, anodes, segments, segmentsB, value, expAn, expSeg(16'h0000, idx, 1'b1));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hex_commit();
    int n;
    int pulses = 0;
    logic [6:0] seg0 = 7'h00;
    logic [6:0] seg3 = 7'h00;
    txBytes = '{8'h31, 8'h61, 8'h46, 8'h33, 8'h0D};
    n = txBytes.size();
    applyStimulus();
    for (int i = 0; i < n; i++) begin
      assertCount++;
      if (obsValue[i+2] !== expValue[i] || obsPend[i+2] !== expPend[i] ||
          obsValid[i+2] !== expValid[i] || obsError[i+2] !== expError[i]) begin
        failCount++;
        $display("[TB] FAIL hex_commit byte%0d: value=%h pend=%0d valid=%b error=%b, expected %h/%0d/%b/%b",
                 i, obsValue[i+2], obsPend[i+2], obsValid[i+2], obsError[i+2],
                 expValue[i], expPend[i], expValid[i], expError[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      assertCount++;
      if (obsPend[i+2] !== 3'(i + 1)) begin
        failCount++;
        $display("[TB] FAIL pend_count_ramp byte%0d: got %0d, expected %0d", i, obsPend[i+2], i + 1);
      end
    end
    foreach (obsValid[i]) if (obsValid[i] === 1'b1) pulses++;
    assertCount++;
    if (pulses != 1 || obsValid[n+1] !== 1'b1 || obsValue[n+2] !== 16'h1AF3 || obsPend[n+2] !== 3'd0) begin
      failCount++;
      $display("[TB] FAIL commit_1AF3: pulses=%0d validAtLatency=%b value=%h pend=%0d, expected 1/1/1af3/0",
               pulses, obsValid[n+1], obsValue[n+2], obsPend[n+2]);
    end
    for (int s = 0; s < 4 * REFRESH; s++) begin
      @(negedge clk);
      if (anodes == 4'b1110) seg0 = segments;
      if (anodes == 4'b0111) seg3 = segments;
    end
    assertCount++;
    if (seg3 !== 7'b1111001 || seg0 !== 7'b0110000) begin
      failCount++;
      $display("[TB] FAIL display_1AF3: digit3=%b digit0=%b, expected 1111001/0110000", seg3, seg0);
    end
  endtask

  task automatic test_overflow_backspace();
    int n;
    int pulses = 0;
    int errs = 0;
    txBytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h08, 8'h39, 8'h0D, 8'h0A};
    n = txBytes.size();
    applyStimulus();
    for (int i = 0; i < n; i++) begin
      assertCount++;
      if (obsValue[i+2] !== expValue[i] || obsPend[i+2] !== expPend[i] ||
          obsValid[i+2] !== expValid[i] || obsError[i+2] !== expError[i]) begin
        failCount++;
        $display("[TB] FAIL overflow_bs byte%0d: value=%h pend=%0d valid=%b error=%b, expected %h/%0d/%b/%b",
                 i, obsValue[i+2], obsPend[i+2], obsValid[i+2], obsError[i+2],
                 expValue[i], expPend[i], expValid[i], expError[i]);
      end
    end
    foreach (obsValid[i]) begin
      if (obsValid[i] === 1'b1) pulses++;
      if (obsError[i] === 1'b1) errs++;
    end
    assertCount++;
    if (pulses != 1 || errs != 0 || obsValue[n+2] !== 16'h2349 || obsPend[6] !== 3'd4) begin
      failCount++;
      $display("[TB] FAIL commit_2349: pulses=%0d errors=%0d value=%h pendAfter5=%0d, expected 1/0/2349/4",
               pulses, errs, obsValue[n+2], obsPend[6]);
    end
  endtask

  task automatic test_invalid_escape();
    int n;
    int pulses = 0;
    int errs = 0;
    txBytes = '{8'h47};
    applyStimulus();
    foreach (obsError[i]) if (obsError[i] === 1'b1) errs++;
    assertCount++;
    if (errs != 1 || obsError[2] !== 1'b1 || obsValid[2] !== 1'b0 || obsPend[3] !== prePend || obsValue[3] !== preValue) begin
      failCount++;
      $display("[TB] FAIL invalid_G: errors=%0d err@lat=%b pend=%0d value=%h, expected 1/1/%0d/%h",
               errs, obsError[2], obsPend[3], obsValue[3], prePend, preValue);
    end
    txBytes = '{8'h37, 8'h1B, 8'h0D};
    n = txBytes.size();
    applyStimulus();
    foreach (obsValid[i]) if (obsValid[i] === 1'b1) pulses++;
    for (int i = 0; i < n; i++) begin
      assertCount++;
      if (obsValue[i+2] !== expValue[i] || obsPend[i+2] !== expPend[i] || obsError[i+2] !== expError[i]) begin
        failCount++;
        $display("[TB] FAIL escape byte%0d: value=%h pend=%0d error=%b, expected %h/%0d/%b",
                 i, obsValue[i+2], obsPend[i+2], obsError[i+2], expValue[i], expPend[i], expError[i]);
      end
    end
    assertCount++;
    if (pulses != 0 || obsValue[n+2] !== preValue) begin
      failCount++;
      $display("[TB] FAIL escape_no_commit: pulses=%0d value=%h, expected 0/%h", pulses, obsValue[n+2], preValue);
    end
  endtask

  task automatic test_blanking();
    int n;
    logic [6:0] seen [4] = '{7'h00, 7'h00, 7'h00, 7'h00};
    txBytes = '{8'h30, 8'h34, 8'h30, 8'h0D};
    n = txBytes.size();
    applyStimulus();
    assertCount++;
    if (obsValue[n+2] !== 16'h0040 || valueB !== 16'h0040) begin
      failCount++;
      $display("[TB] FAIL blank_value: value=%h blankValue=%h, expected 0040", obsValue[n+2], valueB);
    end
    for (int s = 0; s < 4 * REFRESH; s++) begin
      int idx;
      @(negedge clk);
      idx = anodeIdx(anodesB);
      if (idx >= 0) seen[idx] = segmentsB;
    end
    assertCount++;
    if (seen[3] !== 7'b1111111 || seen[2] !== 7'b1111111 || seen[1] !== 7'b0011001 || seen[0] !== 7'b1000000) begin
      failCount++;
      $display("[TB] FAIL blank_digits: d3=%b d2=%b d1=%b d0=%b, expected 1111111/1111111/0011001/1000000",
               seen[3], seen[2], seen[1], seen[0]);
    end
  endtask

  task automatic test_random();
    string hexChars = "0123456789abcdefABCDEF";
    logic [7:0] badBytes [10] = '{8'h47, 8'h7A, 8'h20, 8'h00, 8'hFF, 8'h67, 8'h40, 8'h2F, 8'h3A, 8'h60};
    int n;
    int idxSeen = 0;
    txBytes.delete();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: txBytes.push_back(hexChars[$urandom_range(0, 21)]);
        5:       txBytes.push_back(8'h0D);
        6:       txBytes.push_back(8'h0A);
        7:       txBytes.push_back(8'h08);
        8:       txBytes.push_back(8'h1B);
        default: txBytes.push_back(badBytes[$urandom_range(0, 9)]);
      endcase
    end
    txBytes.push_back(8'h0D);
    n = txBytes.size();
    applyStimulus();
    for (int i = 0; i < n; i++) begin
      assertCount++;
      if (obsValue[i+2] !== expValue[i] || obsPend[i+2] !== expPend[i] ||
          obsValid[i+2] !== expValid[i] || obsError[i+2] !== expError[i]) begin
        failCount++;
        $display("[TB] FAIL random byte%0d (0x%h): value=%h pend=%0d valid=%b error=%b, expected %h/%0d/%b/%b",
                 i, txBytes[i], obsValue[i+2], obsPend[i+2], obsValid[i+2], obsError[i+2],
                 expValue[i], expPend[i], expValid[i], expError[i]);
      end
    end
    for (int s = 0; s < 4 * REFRESH; s++) begin
      int idx;
      @(negedge clk);
      idx = anodeIdx(anodes);
      if (idx >= 0) idxSeen |= (1 << idx);
      assertCount++;
      if (idx < 0 || anodesB !== anodes || segments !== expSeg(modelValue, idx, 1'b0) ||
          segmentsB !== expSeg(modelValue, idx, 1'b1)) begin
        failCount++;
        $display("[TB] FAIL random_scan cycle%0d: anodes=%b seg=%b blankSeg=%b value=%h", s, anodes, segments, segmentsB, modelValue);
      end
    end
    assertCount++;
    if (idxSeen != 15) begin
      failCount++;
      $display("[TB] FAIL scan_coverage: digits seen mask=%b, expected 1111", idxSeen[3:0]);
    end
  endtask

  task automatic test_reset_mid_entry();
    int n;
    txBytes = '{8'h37, 8'h45, 8'h0D};
    n = txBytes.size();
    applyStimulus();
    assertCount++;
    if (obsValue[n+2] !== 16'h007E) begin
      failCount++;
      $display("[TB] FAIL pre_reset_value: value=%h, expected 007e", obsValue[n+2]);
    end
    @(negedge clk); done = 1'b1; dataRX = 8'h41;
    @(negedge clk); dataRX = 8'h42;
    @(negedge clk); rst = 1'b1; dataRX = 8'h43;
    @(negedge clk); rst = 1'b0; done = 1'b0; dataRX = 8'h00;
    modelDigits.delete();
    modelValue = 16'h0000;
    for (int s = 0; s < 6; s++) begin
      assertCount++;
      if (value !== 16'h0000 || pendCount !== 3'd0 || valid !== 1'b0 || error !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL reset_mid_entry cycle%0d: value=%h pend=%0d valid=%b error=%b, expected 0000/0/0/0",
                 s, value, pendCount, valid, error);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    $display("[TB] starting uart_hex_display bench");
    test_reset();
    test_hex_commit();
    test_overflow_backspace();
    test_invalid_escape();
    test_blanking();
    test_random();
    test_reset_mid_entry();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
